// File: rtl/ppl_pkg.sv
// ppl_pkg -- shared definitions for the frame_align_pp ping-pong frame aligner.
//
// Contents:
//   H_DISP_DEF / V_DISP_DEF / FRAME : default panel geometry (480x272 RGB565)
//   wr_state_e                      : writer states (FILL accepts beats, FULL stalls)
//   rd_state_e                      : reader states (IDLE waits for a swap, RUN drains)
//   clog2()                         : ceil(log2(n)), never below 1 so it can size a vector
//   frame_size()                    : pixel count of an H x V frame
package ppl_pkg;

  localparam int H_DISP_DEF = 480;
  localparam int V_DISP_DEF = 272;
  localparam int FRAME      = H_DISP_DEF * V_DISP_DEF;

  typedef enum logic {
    W_FILL = 1'b0,
    W_FULL = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rd_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic int frame_size(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/align_bank_ram.sv
// align_bank_ram -- one frame bank: simple dual-port RAM, one write port and
// one registered read port with read enable.
//
// Ports:
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port, written on the rising edge when we_i=1
//   re_i/raddr_i     : read request; rdata_o updates one cycle later
//   rdata_o          : registered read data, held while re_i=0 so a stalled
//                      consumer sees a stable value
module align_bank_ram
  import ppl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_align_pp.sv
// frame_align_pp -- ping-pong frame aligner. Pixels arrive scattered, each
// tagged with its raster address; once a whole frame has landed in one bank
// the banks swap and the full frame is streamed out in raster order while the
// next frame is collected in the other bank.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_data/in_addr       : scattered pixel and its address y*H_DISP+x
//   in_valid/in_ready     : write handshake; in_ready drops once a frame is full
//   out_data/out_valid    : raster-order pixel stream
//   out_ready             : consumer back-pressure
//   out_sof / out_eol     : first pixel of frame / last pixel of each line
//   out_vs                : one-cycle pulse after every bank swap
//   addr_err              : one-cycle pulse after an accepted out-of-range beat
module frame_align_pp
  import ppl_pkg::*;
#(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_vs,
  output logic              addr_err
);

  localparam int FRAME = frame_size(H_DISP, V_DISP);
  localparam int RAW   = clog2(FRAME);
  localparam int CW    = clog2(FRAME + 1);
  localparam int XW    = clog2(H_DISP);
  localparam int YW    = clog2(V_DISP);

  localparam logic [ADDR_W:0] FRAME_LIM = (ADDR_W + 1)'(FRAME);
  localparam logic [CW-1:0]   WCNT_LAST = CW'(FRAME - 1);
  localparam logic [XW-1:0]   X_LAST    = XW'(H_DISP - 1);
  localparam logic [YW-1:0]   Y_LAST    = YW'(V_DISP - 1);

  // Writer side
  wr_state_e       wr_st_q;
  logic            wsel_q;
  logic [CW-1:0]   wcnt_q;
  logic            in_ready_q;
  logic            addr_err_q;
  logic            out_vs_q;

  // Reader side: p0 is the address/issue stage, p1 the RAM output stage
  rd_state_e       rd_st_q;
  logic [RAW-1:0]  raddr_p0_q;
  logic [XW-1:0]   x_p0_q;
  logic [YW-1:0]   y_p0_q;
  logic            iss_done_p0_q;
  logic            vld_p1_q;
  logic            sof_p1_q;
  logic            eol_p1_q;
  logic            last_p1_q;

  logic              wr_acc;
  logic              in_range;
  logic              wr_en;
  logic              swap;
  logic              out_acc;
  logic              advance;
  logic              issue;
  logic              last_pix_p0;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  assign wr_acc   = in_valid && in_ready_q;
  assign in_range = {1'b0, in_addr} < FRAME_LIM;
  assign wr_en    = wr_acc && in_range;

  // Evaluated on registered states only, so a last write and a last read
  // landing on the same edge swap one cycle later without losing a beat.
  assign swap = (wr_st_q == W_FULL) && (rd_st_q == R_IDLE);

  assign out_acc     = vld_p1_q && out_ready;
  assign advance     = !vld_p1_q || out_ready;
  assign issue       = (rd_st_q == R_RUN) && !iss_done_p0_q && advance;
  assign last_pix_p0 = (x_p0_q == X_LAST) && (y_p0_q == Y_LAST);

  // Writer FSM: counts in-range beats into bank wsel_q until the frame is full
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st_q    <= W_FILL;
      wsel_q     <= 1'b0;
      wcnt_q     <= '0;
      in_ready_q <= 1'b1;
      addr_err_q <= 1'b0;
      out_vs_q   <= 1'b0;
    end else begin
      addr_err_q <= wr_acc && !in_range;
      out_vs_q   <= swap;
      if (swap) begin
        wsel_q     <= ~wsel_q;
        wcnt_q     <= '0;
        wr_st_q    <= W_FILL;
        in_ready_q <= 1'b1;
      end else if (wr_en) begin
        wcnt_q <= wcnt_q + CW'(1);
        if (wcnt_q == WCNT_LAST) begin
          wr_st_q    <= W_FULL;
          in_ready_q <= 1'b0;
        end
      end
    end
  end

  // Reader FSM: walks the drain bank in raster order. The p1 flags only move
  // when the RAM output moves, keeping data and qualifiers aligned on stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st_q       <= R_IDLE;
      raddr_p0_q    <= '0;
      x_p0_q        <= '0;
      y_p0_q        <= '0;
      iss_done_p0_q <= 1'b0;
      vld_p1_q      <= 1'b0;
      sof_p1_q      <= 1'b0;
      eol_p1_q      <= 1'b0;
      last_p1_q     <= 1'b0;
    end else begin
      if (swap) begin
        rd_st_q       <= R_RUN;
        raddr_p0_q    <= '0;
        x_p0_q        <= '0;
        y_p0_q        <= '0;
        iss_done_p0_q <= 1'b0;
      end else if (rd_st_q == R_RUN) begin
        if (issue) begin
          raddr_p0_q <= raddr_p0_q + RAW'(1);
          if (x_p0_q == X_LAST) begin
            x_p0_q <= '0;
            y_p0_q <= (y_p0_q == Y_LAST) ? '0 : y_p0_q + YW'(1);
          end else begin
            x_p0_q <= x_p0_q + XW'(1);
          end
          if (last_pix_p0) begin
            iss_done_p0_q <= 1'b1;
          end
        end
        if (out_acc && last_p1_q) begin
          rd_st_q <= R_IDLE;
        end
      end

      // ---- p0 -> p1: RAM read issued, qualifiers follow the pixel ----
      if (issue) begin
        vld_p1_q  <= 1'b1;
        sof_p1_q  <= (raddr_p0_q == '0);
        eol_p1_q  <= (x_p0_q == X_LAST);
        last_p1_q <= last_pix_p0;
      end else if (out_acc) begin
        vld_p1_q  <= 1'b0;
        sof_p1_q  <= 1'b0;
        eol_p1_q  <= 1'b0;
        last_p1_q <= 1'b0;
      end
    end
  end

  // Bank 0 is written while wsel_q=0 and read while wsel_q=1; bank 1 the reverse.
  align_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (FRAME),
    .AW     (RAW)
  ) u_bank0 (
    .clk_i   (clk),
    .we_i    (wr_en && !wsel_q),
    .waddr_i (in_addr[RAW-1:0]),
    .wdata_i (in_data),
    .re_i    (issue && wsel_q),
    .raddr_i (raddr_p0_q),
    .rdata_o (rdata0)
  );

  align_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (FRAME),
    .AW     (RAW)
  ) u_bank1 (
    .clk_i   (clk),
    .we_i    (wr_en && wsel_q),
    .waddr_i (in_addr[RAW-1:0]),
    .wdata_i (in_data),
    .re_i    (issue && !wsel_q),
    .raddr_i (raddr_p0_q),
    .rdata_o (rdata1)
  );

  // wsel_q cannot change while a frame is being drained, so it also selects
  // the bank whose registered output is on the bus.
  assign out_data  = wsel_q ? rdata0 : rdata1;
  assign out_valid = vld_p1_q;
  assign out_sof   = sof_p1_q;
  assign out_eol   = eol_p1_q;
  assign out_vs    = out_vs_q;
  assign addr_err  = addr_err_q;
  assign in_ready  = in_ready_q;

endmodule
